// File: rtl/gtx_link_reset_seq.sv
// GTX link bring-up sequencer on the free-running DRP clock: CPLL reset pulse,
// lock wait, GT/MAC reset hold, reset-done wait, then link monitoring with retry.
module gtx_link_reset_seq #(
  parameter int PRE_CYCLES     = 60,
  parameter int PLL_RST_CYCLES = 4,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int GT_RST_CYCLES  = 16,
  parameter int DONE_TIMEOUT   = 262143,
  parameter int CW             = 20
) (
  input  logic       drp_clk,
  input  logic       reset,
  input  logic       restart,
  input  logic       pll_locked,
  input  logic       tx_resetdone,
  input  logic       rx_resetdone,
  input  logic       txfsm_resetdone,
  input  logic       rxfsm_resetdone,
  output logic       gt_pll_reset,
  output logic       gt_reset,
  output logic       link_ready,
  output logic [2:0] state_mon,
  output logic [7:0] retry_count,
  output logic       fault
);

  typedef enum logic [2:0] {
    PRE_WAIT  = 3'd0,
    PLL_RST   = 3'd1,
    LOCK_WAIT = 3'd2,
    GT_RST    = 3'd3,
    DONE_WAIT = 3'd4,
    RUNNING   = 3'd5
  } state_t;

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] GT_LAST   = CW'(GT_RST_CYCLES - 1);
  localparam logic [CW-1:0] DONE_LAST = CW'(DONE_TIMEOUT - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            cnt_clr, retry, set_fault;
  logic            lock_p0, lock_p1;
  logic [3:0]      done_p0, done_p1;
  logic            lock_s, done_s;

  // synchronizer stages p0 -> p1
  always_ff @(posedge drp_clk) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
      done_p0 <= '0;
      done_p1 <= '0;
    end else begin
      lock_p0 <= pll_locked;
      lock_p1 <= lock_p0;
      done_p0 <= {txfsm_resetdone, rxfsm_resetdone, tx_resetdone, rx_resetdone};
      done_p1 <= done_p0;
    end
  end

  assign lock_s = lock_p1;
  assign done_s = &done_p1;

  // next-state decision; restart overrides every other transition
  always_comb begin
    state_nx  = state;
    cnt_clr   = 1'b0;
    retry     = 1'b0;
    set_fault = 1'b0;
    if (restart) begin
      state_nx = PRE_WAIT;
      cnt_clr  = 1'b1;
      retry    = 1'b1;
    end else begin
      case (state)
        PRE_WAIT: if (cnt == PRE_LAST) begin
          state_nx = PLL_RST;
          cnt_clr  = 1'b1;
        end
        PLL_RST: if (cnt == PLL_LAST) begin
          state_nx = LOCK_WAIT;
          cnt_clr  = 1'b1;
        end
        LOCK_WAIT: begin
          if (lock_s) begin
            state_nx = GT_RST;
            cnt_clr  = 1'b1;
          end else if (cnt == LOCK_LAST) begin
            state_nx  = PRE_WAIT;
            cnt_clr   = 1'b1;
            retry     = 1'b1;
            set_fault = 1'b1;
          end
        end
        GT_RST: if (cnt == GT_LAST) begin
          // lock lost at the end of the hold: hold GT reset for another full window
          cnt_clr = 1'b1;
          if (lock_s) state_nx = DONE_WAIT;
        end
        DONE_WAIT: begin
          if (done_s && lock_s) begin
            state_nx = RUNNING;
            cnt_clr  = 1'b1;
          end else if ((cnt == DONE_LAST) || !lock_s) begin
            state_nx  = PRE_WAIT;
            cnt_clr   = 1'b1;
            retry     = 1'b1;
            set_fault = (cnt == DONE_LAST);
          end
        end
        RUNNING: if (!lock_s || !done_s) begin
          state_nx = PRE_WAIT;
          cnt_clr  = 1'b1;
          retry    = 1'b1;
        end
        default: begin
          state_nx = PRE_WAIT;
          cnt_clr  = 1'b1;
        end
      endcase
    end
    cnt_nx = cnt_clr ? '0 : cnt + 1'b1;
  end

  // state, counter and decoded outputs registered together
  always_ff @(posedge drp_clk) begin
    if (reset) begin
      state        <= PRE_WAIT;
      cnt          <= '0;
      gt_pll_reset <= 1'b0;
      gt_reset     <= 1'b1;
      link_ready   <= 1'b0;
      state_mon    <= 3'd0;
      retry_count  <= 8'd0;
      fault        <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      gt_pll_reset <= (state_nx == PLL_RST);
      gt_reset     <= (state_nx != RUNNING);
      link_ready   <= (state_nx == RUNNING);
      state_mon    <= state_nx;
      if (retry) retry_count <= sat_inc8(retry_count);
      if (set_fault) fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gtx_link_reset_seq.sv
// Directed bench for gtx_link_reset_seq with short timing parameters.
module tb_gtx_link_reset_seq;

  logic       drp_clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b1;
  logic       tx_resetdone = 1'b1;
  logic       rx_resetdone = 1'b1;
  logic       txfsm_resetdone = 1'b1;
  logic       rxfsm_resetdone = 1'b1;
  logic       gt_pll_reset, gt_reset, link_ready, fault;
  logic [2:0] state_mon;
  logic [7:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  gtx_link_reset_seq #(
    .PRE_CYCLES(8), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(32),
    .GT_RST_CYCLES(4), .DONE_TIMEOUT(32), .CW(20)
  ) dut (
    .drp_clk(drp_clk), .reset(reset), .restart(restart),
    .pll_locked(pll_locked), .tx_resetdone(tx_resetdone),
    .rx_resetdone(rx_resetdone), .txfsm_resetdone(txfsm_resetdone),
    .rxfsm_resetdone(rxfsm_resetdone), .gt_pll_reset(gt_pll_reset),
    .gt_reset(gt_reset), .link_ready(link_ready), .state_mon(state_mon),
    .retry_count(retry_count), .fault(fault)
  );

  always #5 drp_clk = ~drp_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge drp_clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll"},   gt_pll_reset, 0);
    check({tag, "_gtrst"}, gt_reset, 1);
    check({tag, "_ready"}, link_ready, 0);
    check({tag, "_state"}, state_mon, 0);
    check({tag, "_retry"}, retry_count, 0);
    check({tag, "_fault"}, fault, 0);
  endtask

  // leaves the bench at cycle 0: the next edge is the first one with reset low
  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick_n(2);
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target,
                            input int max_cyc, output int n);
    n = 0;
    while (state_mon != target && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_reached"}, state_mon, target);
  endtask

  int n, first_pll, pll_hi, ready_at, cnt4;

  initial begin
    // nominal bring-up
    do_reset("rst0");
    first_pll = -1; pll_hi = 0; ready_at = -1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (gt_pll_reset) begin
        pll_hi++;
        if (first_pll < 0) first_pll = e;
      end
      if (link_ready && ready_at < 0) ready_at = e;
    end
    check("nom_pll_start", first_pll, 8);
    check("nom_pll_width", pll_hi, 4);
    check("nom_ready_edge", ready_at, 18);
    check("nom_gtrst", gt_reset, 0);
    check("nom_state", state_mon, 5);
    check("nom_retry", retry_count, 0);
    check("nom_fault", fault, 0);

    // lock timeout with repeated retries
    pll_locked = 1'b0;
    do_reset("rst1");
    tick_n(43);
    check("lto_state43", state_mon, 2);
    check("lto_fault43", fault, 0);
    tick();
    check("lto_state44", state_mon, 0);
    check("lto_fault44", fault, 1);
    check("lto_retry1", retry_count, 1);
    pll_hi = 0;
    for (int e = 0; e < 44; e++) begin
      tick();
      if (gt_pll_reset) pll_hi++;
    end
    check("lto_pass2_pll", pll_hi, 4);
    check("lto_retry2", retry_count, 2);
    tick_n(44);
    check("lto_retry3", retry_count, 3);
    check("lto_state_pre", state_mon, 0);
    pll_locked = 1'b1;
    wait_state("lto_run", 3'd5, 40, n);
    check("lto_run_cycles", n, 18);
    check("lto_ready", link_ready, 1);
    check("lto_fault_sticky", fault, 1);
    check("lto_retry_kept", retry_count, 3);

    // done timeout
    rx_resetdone = 1'b0;
    do_reset("rst2");
    wait_state("dto_dw", 3'd4, 40, n);
    check("dto_dw_edge", n, 17);
    cnt4 = 0;
    while (state_mon == 3'd4 && cnt4 < 40) begin
      cnt4++;
      tick();
    end
    check("dto_dw_len", cnt4, 32);
    check("dto_state", state_mon, 0);
    check("dto_fault", fault, 1);
    check("dto_retry", retry_count, 1);
    rx_resetdone = 1'b1;

    // loss of lock while running
    do_reset("rst3");
    wait_state("ll_run", 3'd5, 40, n);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    check("ll_ready_t1", link_ready, 1);
    tick();
    check("ll_ready_t2", link_ready, 1);
    tick();
    check("ll_ready_t3", link_ready, 0);
    check("ll_gtrst_t3", gt_reset, 1);
    check("ll_state_t3", state_mon, 0);
    check("ll_retry", retry_count, 1);
    check("ll_fault", fault, 0);
    wait_state("ll_rerun", 3'd5, 40, n);
    check("ll_rerun_cycles", n, 18);

    // restart coinciding with lock timeout
    pll_locked = 1'b0;
    do_reset("rst4");
    wait_state("rvt_lw", 3'd2, 40, n);
    check("rvt_lw_edge", n, 12);
    tick_n(31);
    check("rvt_state43", state_mon, 2);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("rvt_state", state_mon, 0);
    check("rvt_fault", fault, 0);
    check("rvt_retry", retry_count, 1);
    pll_locked = 1'b1;

    // retry saturation, then reset in the middle of GT_RST
    do_reset("rst5");
    for (int i = 0; i < 260; i++) begin
      restart = 1'b1;
      tick();
      restart = 1'b0;
      tick();
    end
    check("sat_retry", retry_count, 255);
    check("sat_fault", fault, 0);
    wait_state("sat_gtrst", 3'd3, 40, n);
    tick();
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    wait_state("post_run", 3'd5, 40, n);
    check("post_run_cycles", n, 18);
    check("post_retry", retry_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
